// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with instruction register, BYPASS
// register and TDO output stage. The state machine and registers update on
// posedge tck. TDO and its enable update on negedge tck.
// Optional feature: define JTAG_TAP_IDCODE_EN to include the 32-bit IDCODE
// register. When it is defined, the reset instruction becomes IDCODE_OPCODE.
module jtag_tap_ctrl #(
   parameter int unsigned       IR_LEN        = 4,
   parameter logic [IR_LEN-1:0] IDCODE_OPCODE = IR_LEN'(1),
   parameter logic [31:0]       IDCODE_VALUE  = 32'h1000_0001
) (
   input  logic              tck,
   input  logic              trst,
   input  logic              tms,
   input  logic              tdi,
   input  logic              user_tdo,
   output logic              tdo,
   output logic              tdo_en,
   output logic              state_tlr,
   output logic              state_capturedr,
   output logic              state_shiftdr,
   output logic              state_updatedr,
   output logic              state_captureir,
   output logic              state_shiftir,
   output logic              state_updateir,
   output logic [IR_LEN-1:0] ir_reg,
   output logic              user_sel
);

   typedef enum logic [3:0] {
      S_TLR      = 4'h0,
      S_RTI      = 4'h1,
      S_SEL_DR   = 4'h2,
      S_CAP_DR   = 4'h3,
      S_SHIFT_DR = 4'h4,
      S_EXIT1_DR = 4'h5,
      S_PAUSE_DR = 4'h6,
      S_EXIT2_DR = 4'h7,
      S_UPD_DR   = 4'h8,
      S_SEL_IR   = 4'h9,
      S_CAP_IR   = 4'hA,
      S_SHIFT_IR = 4'hB,
      S_EXIT1_IR = 4'hC,
      S_PAUSE_IR = 4'hD,
      S_EXIT2_IR = 4'hE,
      S_UPD_IR   = 4'hF
   } tap_state_t;

   // The capture value has bit 0 set and bit 1 clear; all higher bits are ones.
   localparam logic [IR_LEN-1:0] IR_CAPTURE = ~(IR_LEN'(2));
   localparam logic [IR_LEN-1:0] BYPASS_OP  = '1;
`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IR_LEN-1:0] RESET_INSTR = IDCODE_OPCODE;
`else
   localparam logic [IR_LEN-1:0] RESET_INSTR = BYPASS_OP;
`endif

   tap_state_t        r_state;
   tap_state_t        w_state_next;
   logic [IR_LEN-1:0] r_ir_sr;
   logic [IR_LEN-1:0] r_ir;
   logic              r_bypass;
   logic              r_tdo;
   logic              r_tdo_en;
   logic              w_dr_tdo;
   logic              w_user_sel;
`ifdef JTAG_TAP_IDCODE_EN
   logic [31:0]       r_idcode;
`endif

   // TAP state register; trst forces Test-Logic-Reset at any time.
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) r_state <= S_TLR;
      else       r_state <= w_state_next;
   end

   // Standard TMS-driven next-state function.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_TLR:      w_state_next = tms ? S_TLR      : S_RTI;
         S_RTI:      w_state_next = tms ? S_SEL_DR   : S_RTI;
         S_SEL_DR:   w_state_next = tms ? S_SEL_IR   : S_CAP_DR;
         S_CAP_DR:   w_state_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
         S_SHIFT_DR: w_state_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
         S_EXIT1_DR: w_state_next = tms ? S_UPD_DR   : S_PAUSE_DR;
         S_PAUSE_DR: w_state_next = tms ? S_EXIT2_DR : S_PAUSE_DR;
         S_EXIT2_DR: w_state_next = tms ? S_UPD_DR   : S_SHIFT_DR;
         S_UPD_DR:   w_state_next = tms ? S_SEL_DR   : S_RTI;
         S_SEL_IR:   w_state_next = tms ? S_TLR      : S_CAP_IR;
         S_CAP_IR:   w_state_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
         S_SHIFT_IR: w_state_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
         S_EXIT1_IR: w_state_next = tms ? S_UPD_IR   : S_PAUSE_IR;
         S_PAUSE_IR: w_state_next = tms ? S_EXIT2_IR : S_PAUSE_IR;
         S_EXIT2_IR: w_state_next = tms ? S_UPD_IR   : S_SHIFT_IR;
         S_UPD_IR:   w_state_next = tms ? S_SEL_DR   : S_RTI;
         default:    w_state_next = S_TLR;
      endcase
   end

   // IR shift register: capture the fixed pattern, then shift right with tdi entering the MSB.
   always_ff @(posedge tck or negedge trst) begin
      if (!trst)                       r_ir_sr <= IR_CAPTURE;
      else if (r_state == S_CAP_IR)    r_ir_sr <= IR_CAPTURE;
      else if (r_state == S_SHIFT_IR)  r_ir_sr <= {tdi, r_ir_sr[IR_LEN-1:1]};
   end

   // Active instruction. It takes the reset instruction on entry to TLR, so the
   // value holds from the first cycle in TLR, and it loads from the shift register in Update-IR.
   always_ff @(posedge tck or negedge trst) begin
      if (!trst)                        r_ir <= RESET_INSTR;
      else if (w_state_next == S_TLR)   r_ir <= RESET_INSTR;
      else if (r_state == S_UPD_IR)     r_ir <= r_ir_sr;
   end

   // BYPASS cell: clears on capture and passes tdi through with one cycle of delay.
   always_ff @(posedge tck or negedge trst) begin
      if (!trst)                       r_bypass <= 1'b0;
      else if (r_state == S_CAP_DR)    r_bypass <= 1'b0;
      else if (r_state == S_SHIFT_DR)  r_bypass <= tdi;
   end

`ifdef JTAG_TAP_IDCODE_EN
   // IDCODE register: captures the device ID and shifts it out LSB first.
   always_ff @(posedge tck or negedge trst) begin
      if (!trst)                       r_idcode <= IDCODE_VALUE;
      else if (r_state == S_CAP_DR)    r_idcode <= IDCODE_VALUE;
      else if (r_state == S_SHIFT_DR)  r_idcode <= {tdi, r_idcode[31:1]};
   end

   // The user selection excludes BYPASS and the IDCODE opcode. The data-register TDO source follows the instruction.
   always_comb begin
      w_user_sel = (r_ir != BYPASS_OP) && (r_ir != IDCODE_OPCODE);
      w_dr_tdo   = r_bypass;
      if (r_ir == IDCODE_OPCODE) w_dr_tdo = r_idcode[0];
      else if (w_user_sel)       w_dr_tdo = user_tdo;
   end
`else
   // Every opcode except all ones belongs to the user. The data-register TDO source follows the instruction.
   always_comb begin
      w_user_sel = (r_ir != BYPASS_OP);
      w_dr_tdo   = r_bypass;
      if (w_user_sel) w_dr_tdo = user_tdo;
   end
`endif

   // Falling-edge TDO stage: drives only in the shift states and holds the last bit otherwise.
   always_ff @(negedge tck or negedge trst) begin
      if (!trst) begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else if (r_state == S_SHIFT_IR) begin
         r_tdo    <= r_ir_sr[0];
         r_tdo_en <= 1'b1;
      end else if (r_state == S_SHIFT_DR) begin
         r_tdo    <= w_dr_tdo;
         r_tdo_en <= 1'b1;
      end else begin
         r_tdo_en <= 1'b0;
      end
   end

   assign tdo             = r_tdo;
   assign tdo_en          = r_tdo_en;
   assign ir_reg          = r_ir;
   assign user_sel        = w_user_sel;
   assign state_tlr       = (r_state == S_TLR);
   assign state_capturedr = (r_state == S_CAP_DR);
   assign state_shiftdr   = (r_state == S_SHIFT_DR);
   assign state_updatedr  = (r_state == S_UPD_DR);
   assign state_captureir = (r_state == S_CAP_IR);
   assign state_shiftir   = (r_state == S_SHIFT_IR);
   assign state_updateir  = (r_state == S_UPD_IR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed testbench for jtag_tap_ctrl with IR_LEN=4.
// It adapts its expected values when JTAG_TAP_IDCODE_EN is defined.
module tb_jtag_tap_ctrl;

   logic       tck, trst, tms, tdi, user_tdo;
   logic       tdo, tdo_en;
   logic       state_tlr, state_capturedr, state_shiftdr, state_updatedr;
   logic       state_captureir, state_shiftir, state_updateir;
   logic [3:0] ir_reg;
   logic       user_sel;

`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [3:0] RST_IR = 4'b0001;
`else
   localparam logic [3:0] RST_IR = 4'b1111;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] user_pat = '0;
   logic [31:0] dout;
   logic [7:0]  path_bits [16];
   int          path_len  [16];
   logic [6:0]  dec_exp   [16];

   jtag_tap_ctrl dut (
      .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .user_tdo(user_tdo),
      .tdo(tdo), .tdo_en(tdo_en),
      .state_tlr(state_tlr), .state_capturedr(state_capturedr),
      .state_shiftdr(state_shiftdr), .state_updatedr(state_updatedr),
      .state_captureir(state_captureir), .state_shiftir(state_shiftir),
      .state_updateir(state_updateir),
      .ir_reg(ir_reg), .user_sel(user_sel)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The task drives inputs, lets the next posedge sample them, and then returns
   // just after the following negedge. At that point the state and TDO are both settled.
   task automatic step(input logic t_tms, input logic t_tdi);
      tms = t_tms;
      tdi = t_tdi;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   // From RTI or Update-xR, go to Shift-DR.
   task automatic enter_dr();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      user_tdo = user_pat[0];
      step(1'b0, 1'b0);
   endtask

   // From RTI, go to Shift-IR.
   task automatic enter_ir();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
   endtask

   // Shift n bits, LSB first, and collect tdo. The task finishes in Exit1-xR.
   task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] res);
      res = '0;
      for (int i = 0; i < n; i++) begin
         res[i] = tdo;
         chk("shift_tdo_en", {31'b0, tdo_en}, 32'd1);
         if (i + 1 < n) user_tdo = user_pat[i+1];
         step(i == n - 1, din[i]);
      end
   endtask

   // From Exit1-xR, go through Update-xR to RTI.
   task automatic exit_to_rti();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic load_ir(input logic [3:0] val);
      logic [31:0] tmp;
      enter_ir();
      shift_bits(4, {28'b0, val}, tmp);
      exit_to_rti();
   endtask

   initial begin
      // Each entry gives the TMS path from TLR to the state, LSB first, and the path length.
      // The expected one-hot decode is ordered {tlr,capdr,shdr,upddr,capir,shir,updir}.
      path_bits[0]  = 8'b0;        path_len[0]  = 0; dec_exp[0]  = 7'b1000000;
      path_bits[1]  = 8'b0;        path_len[1]  = 1; dec_exp[1]  = 7'b0000000;
      path_bits[2]  = 8'b10;       path_len[2]  = 2; dec_exp[2]  = 7'b0000000;
      path_bits[3]  = 8'b010;      path_len[3]  = 3; dec_exp[3]  = 7'b0100000;
      path_bits[4]  = 8'b0010;     path_len[4]  = 4; dec_exp[4]  = 7'b0010000;
      path_bits[5]  = 8'b1010;     path_len[5]  = 4; dec_exp[5]  = 7'b0000000;
      path_bits[6]  = 8'b01010;    path_len[6]  = 5; dec_exp[6]  = 7'b0000000;
      path_bits[7]  = 8'b101010;   path_len[7]  = 6; dec_exp[7]  = 7'b0000000;
      path_bits[8]  = 8'b11010;    path_len[8]  = 5; dec_exp[8]  = 7'b0001000;
      path_bits[9]  = 8'b110;      path_len[9]  = 3; dec_exp[9]  = 7'b0000000;
      path_bits[10] = 8'b0110;     path_len[10] = 4; dec_exp[10] = 7'b0000100;
      path_bits[11] = 8'b00110;    path_len[11] = 5; dec_exp[11] = 7'b0000010;
      path_bits[12] = 8'b10110;    path_len[12] = 5; dec_exp[12] = 7'b0000000;
      path_bits[13] = 8'b010110;   path_len[13] = 6; dec_exp[13] = 7'b0000000;
      path_bits[14] = 8'b1010110;  path_len[14] = 7; dec_exp[14] = 7'b0000000;
      path_bits[15] = 8'b110110;   path_len[15] = 6; dec_exp[15] = 7'b0000001;

      trst = 1'b0; tms = 1'b1; tdi = 1'b0; user_tdo = 1'b0;
      repeat (2) @(negedge tck);
      #1;
      chk("rst_tlr",      {31'b0, state_tlr}, 32'd1);
      chk("rst_tdo",      {31'b0, tdo},       32'd0);
      chk("rst_tdo_en",   {31'b0, tdo_en},    32'd0);
      chk("rst_ir",       {28'b0, ir_reg},    {28'b0, RST_IR});
      chk("rst_user_sel", {31'b0, user_sel},  32'd0);
      trst = 1'b1;

      // Visit every state, check its decode, then return to TLR with five TMS=1 cycles.
      for (int s = 0; s < 16; s++) begin
         for (int j = 0; j < path_len[s]; j++) step(path_bits[s][j], 1'b0);
         chk($sformatf("decode_s%0d", s),
             {25'b0, state_tlr, state_capturedr, state_shiftdr, state_updatedr,
              state_captureir, state_shiftir, state_updateir}, {25'b0, dec_exp[s]});
         chk($sformatf("tdo_en_s%0d", s), {31'b0, tdo_en}, {31'b0, (s == 4 || s == 11)});
         repeat (5) step(1'b1, 1'b0);
         chk($sformatf("tlr_from_s%0d", s), {31'b0, state_tlr}, 32'd1);
         chk($sformatf("ir_from_s%0d", s),  {28'b0, ir_reg}, {28'b0, RST_IR});
      end

      // IR capture pattern shifted out with tdi=0.
      step(1'b0, 1'b0);
      chk("rti_not_tlr", {31'b0, state_tlr}, 32'd0);
      enter_ir();
      shift_bits(4, 32'h0, dout);
      chk("ir_capture_tdo", dout, 32'hD);
      chk("exit_tdo_en",    {31'b0, tdo_en}, 32'd0);
      exit_to_rti();
      chk("ir_zero",        {28'b0, ir_reg}, 32'h0);
      chk("ir_zero_usel",   {31'b0, user_sel}, 32'd1);

      // Assert trst during Shift-IR after two bits. Partial data must not reach ir_reg.
      enter_ir();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      trst = 1'b0;
      #1;
      chk("abort_tlr",    {31'b0, state_tlr}, 32'd1);
      chk("abort_tdo_en", {31'b0, tdo_en},    32'd0);
      chk("abort_tdo",    {31'b0, tdo},       32'd0);
      chk("abort_ir",     {28'b0, ir_reg},    {28'b0, RST_IR});
      trst = 1'b1;

      // Run a DR shift straight after reset, using the reset instruction.
      step(1'b0, 1'b0);
`ifdef JTAG_TAP_IDCODE_EN
      enter_dr();
      shift_bits(32, 32'h0, dout);
      chk("idcode_after_rst", dout, 32'h1000_0001);
`else
      enter_dr();
      shift_bits(3, 32'h7, dout);
      chk("bypass_after_rst", dout, 32'h6);
`endif
      exit_to_rti();

      // Load opcode 0001 and go from Update-IR directly to Capture-DR.
      user_pat = 32'h0000_00B2;
      enter_ir();
      shift_bits(4, 32'h1, dout);
      step(1'b1, 1'b0);
      enter_dr();
      chk("ir_0001", {28'b0, ir_reg}, 32'h1);
`ifdef JTAG_TAP_IDCODE_EN
      chk("usel_idcode", {31'b0, user_sel}, 32'd0);
      shift_bits(32, 32'h0, dout);
      chk("idcode_direct", dout, 32'h1000_0001);
`else
      chk("usel_user", {31'b0, user_sel}, 32'd1);
      shift_bits(8, 32'h0, dout);
      chk("user_tdo_path", dout, 32'hB2);
`endif
      exit_to_rti();
      user_pat = '0;

      // Check BYPASS with explicit all-ones: the output is tdi delayed by one bit and starts at 0.
      load_ir(4'b1111);
      chk("ir_ones",      {28'b0, ir_reg},   32'hF);
      chk("ir_ones_usel", {31'b0, user_sel}, 32'd0);
      enter_dr();
      shift_bits(4, 32'hD, dout);
      chk("bypass_tdo",   dout, 32'hA);
      chk("hold_tdo",     {31'b0, tdo},    32'd1);
      chk("hold_tdo_en",  {31'b0, tdo_en}, 32'd0);
      exit_to_rti();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
